// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - HI/LO multiply/divide unit; MULDIV_MADD_EN enables madd/maddu/msub/msubu
module hilo_muldiv #(
  parameter int MUL_LAT = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  mul_func,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  localparam logic [5:0] MUL_CNT_INIT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_CNT_INIT = 6'd32;

  state_t      state;
  logic [5:0]  cnt;
  logic [63:0] prod;

  // Divider datapath: partial remainder, quotient/dividend shift register, divisor
  logic [31:0] div_rem;
  logic [31:0] div_quo;
  logic [31:0] div_dsr;
  logic [31:0] div_a;
  logic        neg_q;
  logic        neg_r;
  logic        div_zero;

  // Decoded command
  logic        dec_mul;
  logic        dec_div;
  logic        dec_sgn;
  logic        dec_sethi;
  logic        dec_setlo;

`ifdef MULDIV_MADD_EN
  // Accumulate mode captured with the product: 0 load, 1 add, 2 subtract
  logic [1:0]  dec_op;
  logic [1:0]  acc_op;
`endif

  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] mul_prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] div_shl;
  logic [32:0] div_trial;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [63:0] acc;

  // Decode the command code into operation class and signedness
  always_comb begin
    dec_mul   = 1'b0;
    dec_div   = 1'b0;
    dec_sgn   = 1'b0;
    dec_sethi = 1'b0;
    dec_setlo = 1'b0;
`ifdef MULDIV_MADD_EN
    dec_op    = 2'd0;
`endif
    case (mul_func)
      4'd1: begin dec_mul = 1'b1; dec_sgn = 1'b1; end
      4'd2: begin dec_mul = 1'b1; end
      4'd3: begin dec_div = 1'b1; dec_sgn = 1'b1; end
      4'd4: begin dec_div = 1'b1; end
      4'd5: begin dec_sethi = 1'b1; end
      4'd6: begin dec_setlo = 1'b1; end
`ifdef MULDIV_MADD_EN
      4'd7:  begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_op = 2'd1; end
      4'd8:  begin dec_mul = 1'b1; dec_op = 2'd1; end
      4'd9:  begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_op = 2'd2; end
      4'd10: begin dec_mul = 1'b1; dec_op = 2'd2; end
`endif
      default: begin end
    endcase
  end

  // Full 64-bit product; sign extension before a modulo-2^64 multiply gives the signed result
  always_comb begin
    ext_a    = {{32{dec_sgn & in_a[31]}}, in_a};
    ext_b    = {{32{dec_sgn & in_b[31]}}, in_b};
    mul_prod = ext_a * ext_b;
  end

  // Operand magnitudes for the divider; 0x80000000 negates to itself and is read as unsigned
  always_comb begin
    a_mag = (dec_sgn && in_a[31]) ? (~in_a + 32'd1) : in_a;
    b_mag = (dec_sgn && in_b[31]) ? (~in_b + 32'd1) : in_b;
  end

  // One restoring-division step: shift in the next dividend bit and try to subtract
  always_comb begin
    div_shl   = {div_rem, div_quo[31]};
    div_trial = div_shl - {1'b0, div_dsr};
    if (!div_trial[32]) begin
      rem_next = div_trial[31:0];
      quo_next = {div_quo[30:0], 1'b1};
    end else begin
      rem_next = div_shl[31:0];
      quo_next = {div_quo[30:0], 1'b0};
    end
  end

  // Sign correction applied on the commit edge
  always_comb begin
    q_fix = neg_q ? (~div_quo + 32'd1) : div_quo;
    r_fix = neg_r ? (~div_rem + 32'd1) : div_rem;
  end

  // Multiply commit value; accumulating forms use the HI/LO pair as it stands at commit
  always_comb begin
`ifdef MULDIV_MADD_EN
    case (acc_op)
      2'd1:    acc = {hi, lo} + prod;
      2'd2:    acc = {hi, lo} - prod;
      default: acc = prod;
    endcase
`else
    acc = prod;
`endif
  end

  // Main control: accept commands in IDLE, count down the multiply, iterate the divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 6'd0;
      prod     <= 64'd0;
      div_rem  <= 32'd0;
      div_quo  <= 32'd0;
      div_dsr  <= 32'd0;
      div_a    <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      busy     <= 1'b0;
`ifdef MULDIV_MADD_EN
      acc_op   <= 2'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (dec_sethi) begin
            hi <= in_a;
          end
          if (dec_setlo) begin
            lo <= in_a;
          end
          if (dec_mul) begin
            prod  <= mul_prod;
            cnt   <= MUL_CNT_INIT;
            state <= S_MUL;
            busy  <= 1'b1;
`ifdef MULDIV_MADD_EN
            acc_op <= dec_op;
`endif
          end
          if (dec_div) begin
            div_rem  <= 32'd0;
            div_quo  <= a_mag;
            div_dsr  <= b_mag;
            div_a    <= in_a;
            neg_q    <= dec_sgn & (in_a[31] ^ in_b[31]);
            neg_r    <= dec_sgn & in_a[31];
            div_zero <= (in_b == 32'd0);
            cnt      <= DIV_CNT_INIT;
            state    <= S_DIV;
            busy     <= 1'b1;
          end
        end
        S_MUL: begin
          if (cnt == 6'd0) begin
            hi    <= acc[63:32];
            lo    <= acc[31:0];
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        S_DIV: begin
          if (cnt == 6'd0) begin
            if (div_zero) begin
              lo <= 32'hFFFF_FFFF;
              hi <= div_a;
            end else begin
              lo <= q_fix;
              hi <= r_fix;
            end
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            div_rem <= rem_next;
            div_quo <= quo_next;
            cnt     <= cnt - 6'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - self-checking bench for hilo_muldiv
module tb_hilo_muldiv;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  mul_func = 4'd0;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  hilo_muldiv #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mul_func(mul_func),
    .in_a(in_a),
    .in_b(in_b),
    .hi(hi),
    .lo(lo),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: remaining latency, pending result, accumulate mode
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          m_cnt = 0;
  int          m_kind = 0;
  logic [63:0] m_val = 64'd0;

  function automatic logic [63:0] mul_model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    return 64'(sa * sb);
  endfunction

  function automatic logic [63:0] div_model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint unsigned am;
    longint unsigned bm;
    longint unsigned q;
    longint unsigned r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    am = (sgn && a[31]) ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
    bm = (sgn && b[31]) ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
    q = am / bm;
    r = am % bm;
    if (sgn && (a[31] != b[31])) q = -q;
    if (sgn && a[31]) r = -r;
    return {r[31:0], q[31:0]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi  <= 32'd0;
      m_lo  <= 32'd0;
      m_cnt <= 0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        case (m_kind)
          1:       {m_hi, m_lo} <= {m_hi, m_lo} + m_val;
          2:       {m_hi, m_lo} <= {m_hi, m_lo} - m_val;
          default: {m_hi, m_lo} <= m_val;
        endcase
      end
    end else begin
      case (mul_func)
        4'd1: begin m_val <= mul_model(1, in_a, in_b); m_kind <= 0; m_cnt <= MUL_LAT; end
        4'd2: begin m_val <= mul_model(0, in_a, in_b); m_kind <= 0; m_cnt <= MUL_LAT; end
        4'd3: begin m_val <= div_model(1, in_a, in_b); m_kind <= 0; m_cnt <= DIV_LAT; end
        4'd4: begin m_val <= div_model(0, in_a, in_b); m_kind <= 0; m_cnt <= DIV_LAT; end
        4'd5: m_hi <= in_a;
        4'd6: m_lo <= in_a;
`ifdef MULDIV_MADD_EN
        4'd7:  begin m_val <= mul_model(1, in_a, in_b); m_kind <= 1; m_cnt <= MUL_LAT; end
        4'd8:  begin m_val <= mul_model(0, in_a, in_b); m_kind <= 1; m_cnt <= MUL_LAT; end
        4'd9:  begin m_val <= mul_model(1, in_a, in_b); m_kind <= 2; m_cnt <= MUL_LAT; end
        4'd10: begin m_val <= mul_model(0, in_a, in_b); m_kind <= 2; m_cnt <= MUL_LAT; end
`endif
        default: begin end
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_hi", {32'd0, hi}, {32'd0, m_hi});
      check("model_lo", {32'd0, lo}, {32'd0, m_lo});
      check("model_busy", {63'd0, busy}, {63'd0, (m_cnt != 0)});
    end
  end

  // Issue one command (entered at a negedge) and count the busy cycles that follow
  task automatic run_cmd(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b, output int n);
    mul_func = f;
    in_a = a;
    in_b = b;
    @(posedge clk);
    @(negedge clk);
    mul_func = 4'd0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("busy_timeout", 64'(n), 64'd0);
  endtask

  int n;

  initial begin
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd(4'd1, 32'hFFFF_FFFD, 32'd5, n);
    check("mult_lat", 64'(n), 64'(MUL_LAT));
    check("mult_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    run_cmd(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    check("multu_res", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    run_cmd(4'd5, 32'h1234, 32'd0, n);
    check("mthi_lat", 64'(n), 64'd0);
    check("mthi_res", {hi, lo}, 64'h0000_1234_0000_0001);

    run_cmd(4'd3, 32'hFFFF_FFF9, 32'd2, n);
    check("div_lat", 64'(n), 64'(DIV_LAT));
    check("div_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_cmd(4'd4, 32'd100, 32'd0, n);
    check("divu0_lat", 64'(n), 64'(DIV_LAT));
    check("divu0_res", {hi, lo}, 64'h0000_0064_FFFF_FFFF);

    run_cmd(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("div_ovf_res", {hi, lo}, 64'h0000_0000_8000_0000);

    run_cmd(4'd3, 32'd7, 32'hFFFF_FFFE, n);
    check("div_negb_res", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

    run_cmd(4'd4, 32'hFFFF_FFFF, 32'h10, n);
    check("divu_res", {hi, lo}, 64'h0000_000F_0FFF_FFFF);

    run_cmd(4'd3, 32'hFFFF_FFF9, 32'd0, n);
    check("div0_res", {hi, lo}, 64'hFFFF_FFF9_FFFF_FFFF);

    run_cmd(4'd5, 32'd0, 32'd0, n);
    run_cmd(4'd6, 32'hFFFF_FFFF, 32'd0, n);
    run_cmd(4'd8, 32'd1, 32'd1, n);
`ifdef MULDIV_MADD_EN
    check("maddu_lat", 64'(n), 64'(MUL_LAT));
    check("maddu_res", {hi, lo}, 64'h0000_0001_0000_0000);
    run_cmd(4'd9, 32'd1, 32'd1, n);
    check("msub_res", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
    run_cmd(4'd7, 32'hFFFF_FFFF, 32'd2, n);
    check("madd_res", {hi, lo}, 64'h0000_0000_FFFF_FFFD);
`else
    check("maddu_lat", 64'(n), 64'd0);
    check("maddu_res", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

    run_cmd(4'd12, 32'hDEAD_BEEF, 32'd3, n);
    check("code12_lat", 64'(n), 64'd0);

    // MULT presented mid-divide must be ignored
    mul_func = 4'd3;
    in_a = 32'd20;
    in_b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    mul_func = 4'd0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (n == 10) begin
        mul_func = 4'd1;
        in_a = 32'd2;
        in_b = 32'd3;
      end else begin
        mul_func = 4'd0;
      end
      @(negedge clk);
    end
    mul_func = 4'd0;
    check("ign_lat", 64'(n), 64'(DIV_LAT));
    check("ign_res", {hi, lo}, 64'h0000_0002_0000_0006);
    repeat (3) @(negedge clk);
    check("ign_idle", {63'd0, busy}, 64'd0);

    // Asynchronous reset in the middle of a divide
    mul_func = 4'd3;
    in_a = 32'd1000;
    in_b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    mul_func = 4'd0;
    for (int i = 1; i < 12; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run_cmd(4'd1, 32'd2, 32'd3, n);
    check("post_rst_lat", 64'(n), 64'(MUL_LAT));
    check("post_rst_res", {hi, lo}, 64'h0000_0000_0000_0006);

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
